// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared elevator types: scan direction encoding and default floor width
package elevator_pkg;

    localparam int FLOOR_W_DEF = 5;

    typedef enum logic [1:0] {
        DIR_IDLE = 2'b00,
        DIR_UP   = 2'b01,
        DIR_DOWN = 2'b10
    } dir_t;

endpackage

// File: rtl/floor_prio_search.sv
// rtl/floor_prio_search.sv - nearest pending floor above/below the car, plus pending-at-car flag
module floor_prio_search
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = 8,
    parameter int FLOOR_W    = FLOOR_W_DEF
) (
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]    cur_floor,
    output logic [FLOOR_W-1:0]    above_idx,
    output logic                  above_found,
    output logic [FLOOR_W-1:0]    below_idx,
    output logic                  below_found,
    output logic                  here
);

    // Descending scan keeps the lowest hit above; ascending scan keeps the highest hit below.
    always_comb begin
        above_idx   = '0;
        above_found = 1'b0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending[i] && (FLOOR_W'(i) > cur_floor)) begin
                above_idx   = FLOOR_W'(i);
                above_found = 1'b1;
            end
        end
    end

    always_comb begin
        below_idx   = '0;
        below_found = 1'b0;
        here        = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending[i] && (FLOOR_W'(i) < cur_floor)) begin
                below_idx   = FLOOR_W'(i);
                below_found = 1'b1;
            end
            if (pending[i] && (FLOOR_W'(i) == cur_floor)) begin
                here = 1'b1;
            end
        end
    end

endmodule

// File: rtl/call_dispatcher.sv
// rtl/call_dispatcher.sv - latches floor calls and issues SCAN-ordered target floors
module call_dispatcher
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = 8,
    parameter int FLOOR_W    = FLOOR_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] call_btn,
    input  logic [FLOOR_W-1:0]    cur_floor,
    input  logic                  door,
    output logic [FLOOR_W-1:0]    r_f,
    output logic                  req_valid,
    output logic [1:0]            dir,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  floor_err
);

    logic [NUM_FLOORS-1:0] btn_s;
    logic [NUM_FLOORS-1:0] btn_q;
    logic [NUM_FLOORS-1:0] rise;
    logic [NUM_FLOORS-1:0] retire_mask;
    logic                  in_range;
    logic [FLOOR_W-1:0]    sel_floor;

    dir_t                  state, state_nxt;
    logic [FLOOR_W-1:0]    r_f_nxt;

    logic [FLOOR_W-1:0]    above_idx, below_idx;
    logic                  above_found, below_found, here;

    // Widened compare so NUM_FLOORS == 2**FLOOR_W does not wrap to zero.
    assign in_range  = {1'b0, cur_floor} < (FLOOR_W + 1)'(NUM_FLOORS);
    assign sel_floor = in_range ? cur_floor : FLOOR_W'(NUM_FLOORS - 1);
    assign rise      = btn_s & ~btn_q;

    always_comb begin
        retire_mask = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            retire_mask[i] = door && in_range && (FLOOR_W'(i) == cur_floor);
        end
    end

    floor_prio_search #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_search (
        .pending     (pending),
        .cur_floor   (sel_floor),
        .above_idx   (above_idx),
        .above_found (above_found),
        .below_idx   (below_idx),
        .below_found (below_found),
        .here        (here)
    );

    // Retire is applied after set so a press at the open-door floor is dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_s     <= '0;
            btn_q     <= '0;
            pending   <= '0;
            floor_err <= 1'b0;
        end else begin
            btn_s     <= call_btn;
            btn_q     <= btn_s;
            pending   <= (pending | rise) & ~retire_mask;
            floor_err <= floor_err | ~in_range;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= DIR_IDLE;
            r_f       <= '0;
            req_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            r_f       <= r_f_nxt;
            req_valid <= |pending;
        end
    end

    always_comb begin
        state_nxt = state;
        r_f_nxt   = r_f;
        case (state)
            DIR_IDLE: begin
                if (|pending) begin
                    if (here) begin
                        r_f_nxt   = sel_floor;
                        state_nxt = DIR_UP;
                    end else if (above_found) begin
                        r_f_nxt   = above_idx;
                        state_nxt = DIR_UP;
                    end else begin
                        r_f_nxt   = below_idx;
                        state_nxt = DIR_DOWN;
                    end
                end
            end
            DIR_UP: begin
                if (here) begin
                    r_f_nxt = sel_floor;
                end else if (above_found) begin
                    r_f_nxt = above_idx;
                end else if (below_found) begin
                    r_f_nxt   = below_idx;
                    state_nxt = DIR_DOWN;
                end else begin
                    state_nxt = DIR_IDLE;
                end
            end
            DIR_DOWN: begin
                if (here) begin
                    r_f_nxt = sel_floor;
                end else if (below_found) begin
                    r_f_nxt = below_idx;
                end else if (above_found) begin
                    r_f_nxt   = above_idx;
                    state_nxt = DIR_UP;
                end else begin
                    state_nxt = DIR_IDLE;
                end
            end
            default: state_nxt = DIR_IDLE;
        endcase
    end

    assign dir = state;

endmodule

// File: tb/tb_call_dispatcher.sv
// tb/tb_call_dispatcher.sv - directed self-checking bench for call_dispatcher
module tb_call_dispatcher;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] call_btn;
    logic [4:0] cur_floor;
    logic       door;
    logic [4:0] r_f;
    logic       req_valid;
    logic [1:0] dir;
    logic [7:0] pending;
    logic       floor_err;

    int checks   = 0;
    int failures = 0;

    call_dispatcher #(.NUM_FLOORS(8), .FLOOR_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .call_btn  (call_btn),
        .cur_floor (cur_floor),
        .door      (door),
        .r_f       (r_f),
        .req_valid (req_valid),
        .dir       (dir),
        .pending   (pending),
        .floor_err (floor_err)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input logic [7:0] mask);
        call_btn = mask;
        tick(1);
        call_btn = '0;
        tick(3);
    endtask

    task automatic test_reset;
        reset     = 1'b0;
        cur_floor = 5'd0;
        door      = 1'b0;
        for (int i = 0; i < 5; i++) begin
            call_btn = 8'($urandom);
            tick(1);
        end
        checks++; if (r_f !== 5'd0) begin failures++; $display("FAIL reset_r_f got=%0d exp=0", r_f); end
        checks++; if (req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%0b exp=0", req_valid); end
        checks++; if (dir !== 2'b00) begin failures++; $display("FAIL reset_dir got=%0b exp=00", dir); end
        checks++; if (pending !== 8'h00) begin failures++; $display("FAIL reset_pending got=%0h exp=00", pending); end
        checks++; if (floor_err !== 1'b0) begin failures++; $display("FAIL reset_floor_err got=%0b exp=0", floor_err); end
        call_btn = '0;
        #2 reset = 1'b1;
        tick(2);
        press(8'h26);
        checks++; if (pending !== 8'h26) begin failures++; $display("FAIL midreset_setup_pending got=%0h exp=26", pending); end
        checks++; if (r_f !== 5'd1) begin failures++; $display("FAIL midreset_setup_r_f got=%0d exp=1", r_f); end
        #2 reset = 1'b0;
        #1;
        checks++; if (pending !== 8'h00) begin failures++; $display("FAIL midreset_pending got=%0h exp=00", pending); end
        checks++; if (r_f !== 5'd0) begin failures++; $display("FAIL midreset_r_f got=%0d exp=0", r_f); end
        checks++; if (req_valid !== 1'b0) begin failures++; $display("FAIL midreset_req_valid got=%0b exp=0", req_valid); end
        checks++; if (dir !== 2'b00) begin failures++; $display("FAIL midreset_dir got=%0b exp=00", dir); end
        #1 reset = 1'b1;
        tick(2);
    endtask

    task automatic test_single_call;
        cur_floor = 5'd0;
        door      = 1'b0;
        call_btn  = 8'h08;
        tick(1);
        call_btn = '0;
        checks++; if (pending !== 8'h00) begin failures++; $display("FAIL single_lat_n got=%0h exp=00", pending); end
        tick(1);
        checks++; if (pending !== 8'h08) begin failures++; $display("FAIL single_pending got=%0h exp=08", pending); end
        checks++; if (req_valid !== 1'b0) begin failures++; $display("FAIL single_lat_valid got=%0b exp=0", req_valid); end
        tick(1);
        checks++; if (r_f !== 5'd3) begin failures++; $display("FAIL single_r_f got=%0d exp=3", r_f); end
        checks++; if (req_valid !== 1'b1) begin failures++; $display("FAIL single_req_valid got=%0b exp=1", req_valid); end
        checks++; if (dir !== 2'b01) begin failures++; $display("FAIL single_dir got=%0b exp=01", dir); end
        cur_floor = 5'd3;
        door      = 1'b1;
        tick(2);
        door = 1'b0;
        checks++; if (pending !== 8'h00) begin failures++; $display("FAIL single_retire_pending got=%0h exp=00", pending); end
        checks++; if (req_valid !== 1'b0) begin failures++; $display("FAIL single_retire_valid got=%0b exp=0", req_valid); end
        checks++; if (dir !== 2'b00) begin failures++; $display("FAIL single_retire_dir got=%0b exp=00", dir); end
    endtask

    task automatic test_scan_order;
        cur_floor = 5'd2;
        door      = 1'b0;
        press(8'h62);
        checks++; if (dir !== 2'b01) begin failures++; $display("FAIL scan_up_dir got=%0b exp=01", dir); end
        checks++; if (r_f !== 5'd5) begin failures++; $display("FAIL scan_first_r_f got=%0d exp=5", r_f); end
        cur_floor = 5'd5; door = 1'b1; tick(1); door = 1'b0; tick(1);
        checks++; if (r_f !== 5'd6) begin failures++; $display("FAIL scan_second_r_f got=%0d exp=6", r_f); end
        cur_floor = 5'd6; door = 1'b1; tick(1); door = 1'b0; tick(1);
        checks++; if (dir !== 2'b10) begin failures++; $display("FAIL scan_reverse_dir got=%0b exp=10", dir); end
        checks++; if (r_f !== 5'd1) begin failures++; $display("FAIL scan_reverse_r_f got=%0d exp=1", r_f); end
        cur_floor = 5'd1; door = 1'b1; tick(1); door = 1'b0; tick(1);
        checks++; if (dir !== 2'b00) begin failures++; $display("FAIL scan_idle_dir got=%0b exp=00", dir); end
        checks++; if (req_valid !== 1'b0) begin failures++; $display("FAIL scan_idle_valid got=%0b exp=0", req_valid); end
        checks++; if (r_f !== 5'd1) begin failures++; $display("FAIL scan_idle_hold_r_f got=%0d exp=1", r_f); end
    endtask

    task automatic test_same_floor;
        cur_floor = 5'd4;
        door      = 1'b1;
        press(8'h10);
        checks++; if (pending !== 8'h00) begin failures++; $display("FAIL samefloor_open_pending got=%0h exp=00", pending); end
        door = 1'b0;
        press(8'h10);
        checks++; if (pending !== 8'h10) begin failures++; $display("FAIL samefloor_closed_pending got=%0h exp=10", pending); end
        checks++; if (r_f !== 5'd4) begin failures++; $display("FAIL samefloor_r_f got=%0d exp=4", r_f); end
        door = 1'b1; tick(2); door = 1'b0; tick(1);
    endtask

    task automatic test_held_button;
        cur_floor = 5'd4;
        door      = 1'b0;
        call_btn  = 8'h04;
        tick(3);
        checks++; if (pending !== 8'h04) begin failures++; $display("FAIL held_set_pending got=%0h exp=04", pending); end
        cur_floor = 5'd2; door = 1'b1; tick(2); door = 1'b0;
        tick(15);
        checks++; if (pending !== 8'h00) begin failures++; $display("FAIL held_no_reset got=%0h exp=00", pending); end
        call_btn = '0;
        tick(2);
        press(8'h04);
        checks++; if (pending !== 8'h04) begin failures++; $display("FAIL held_repress got=%0h exp=04", pending); end
        door = 1'b1; tick(2); door = 1'b0; tick(1);
    endtask

    task automatic test_fault;
        cur_floor = 5'd0;
        door      = 1'b0;
        press(8'h80);
        checks++; if (floor_err !== 1'b0) begin failures++; $display("FAIL fault_pre_err got=%0b exp=0", floor_err); end
        cur_floor = 5'd9;
        door      = 1'b1;
        tick(2);
        checks++; if (pending !== 8'h80) begin failures++; $display("FAIL fault_no_retire got=%0h exp=80", pending); end
        checks++; if (floor_err !== 1'b1) begin failures++; $display("FAIL fault_err got=%0b exp=1", floor_err); end
        checks++; if (r_f !== 5'd7) begin failures++; $display("FAIL fault_r_f got=%0d exp=7", r_f); end
        cur_floor = 5'd3;
        door      = 1'b0;
        tick(2);
        checks++; if (floor_err !== 1'b1) begin failures++; $display("FAIL fault_sticky got=%0b exp=1", floor_err); end
        checks++; if (r_f !== 5'd7) begin failures++; $display("FAIL fault_inrange_r_f got=%0d exp=7", r_f); end
    endtask

    initial begin
        call_btn  = '0;
        cur_floor = '0;
        door      = 1'b0;
        reset     = 1'b0;
        test_reset;
        test_single_call;
        test_scan_order;
        test_same_floor;
        test_held_button;
        test_fault;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
